// File: rtl/multi_timer.sv
// NCH independent cycle timers with one-shot or auto-reload mode, abort and live count.
// Optional per-channel tick prescaler enabled by defining MULTI_TIMER_PRESCALE_EN.
module multi_timer #(
    parameter int NCH    = 1,
    parameter int CWIDTH = 32,
    parameter int PWIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NCH-1:0]          i_start,
    input  logic [NCH-1:0]          i_stop,
    input  logic [NCH-1:0]          i_periodic,
    input  logic [NCH*CWIDTH-1:0]   i_cycles,
`ifdef MULTI_TIMER_PRESCALE_EN
    input  logic [PWIDTH-1:0]       i_prescale,
`endif
    output logic [NCH-1:0]          o_busy,
    output logic [NCH-1:0]          o_expire,
    output logic [NCH-1:0]          o_done,
    output logic [NCH*CWIDTH-1:0]   o_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        state_t              state_r, state_next_s;
        logic [CWIDTH-1:0]   count_r, count_next_s;
        logic [CWIDTH-1:0]   target_r, target_next_s;
        logic [CWIDTH-1:0]   last_s;
        logic                mode_r, mode_next_s;
        logic                done_r, done_next_s;
        logic                expire_r, expire_next_s;
        logic                busy_r;
        logic                tick_s;

`ifdef MULTI_TIMER_PRESCALE_EN
        logic [PWIDTH-1:0]   presc_r, presc_next_s;

        // Tick when the divider reaches P; >= keeps a lowered live P from wrapping the divider.
        always_comb begin
            tick_s       = (presc_r >= i_prescale);
            presc_next_s = presc_r;
            if (i_start[k]) begin
                presc_next_s = '0;
            end else if ((state_r == ST_IDLE) || i_stop[k]) begin
                presc_next_s = presc_r;
            end else if (tick_s) begin
                presc_next_s = '0;
            end else begin
                presc_next_s = presc_r + PWIDTH'(1);
            end
        end

        // Prescaler register
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_next_s;
            end
        end
`else
        assign tick_s = 1'b1;
`endif

        // A zero target behaves as one, so the terminal count value is max(N,1)-1.
        assign last_s = (target_r == '0) ? '0 : (target_r - CWIDTH'(1));

        // Next-state and output decode; start overrides everything, stop beats counting.
        always_comb begin
            state_next_s  = state_r;
            count_next_s  = count_r;
            target_next_s = target_r;
            mode_next_s   = mode_r;
            done_next_s   = done_r;
            expire_next_s = 1'b0;
            if (i_start[k]) begin
                state_next_s  = ST_ARMED;
                target_next_s = i_cycles[k*CWIDTH +: CWIDTH];
                mode_next_s   = i_periodic[k];
                count_next_s  = '0;
                done_next_s   = 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_next_s = ST_IDLE;
                    end
                    ST_ARMED, ST_RUN: begin
                        if (i_stop[k]) begin
                            state_next_s = ST_IDLE;
                        end else begin
                            state_next_s = ST_RUN;
                            if (tick_s) begin
                                if (count_r == last_s) begin
                                    expire_next_s = 1'b1;
                                    done_next_s   = 1'b1;
                                    if (mode_r) begin
                                        count_next_s = '0;
                                    end else begin
                                        count_next_s = count_r + CWIDTH'(1);
                                        state_next_s = ST_IDLE;
                                    end
                                end else begin
                                    count_next_s = count_r + CWIDTH'(1);
                                end
                            end else begin
                                count_next_s = count_r;
                            end
                        end
                    end
                    default: begin
                        state_next_s = ST_IDLE;
                    end
                endcase
            end
        end

        // Channel state and registered outputs
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                state_r  <= ST_IDLE;
                count_r  <= '0;
                target_r <= '0;
                mode_r   <= 1'b0;
                done_r   <= 1'b0;
                expire_r <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                state_r  <= state_next_s;
                count_r  <= count_next_s;
                target_r <= target_next_s;
                mode_r   <= mode_next_s;
                done_r   <= done_next_s;
                expire_r <= expire_next_s;
                busy_r   <= (state_next_s == ST_RUN);
            end
        end

        assign o_busy[k]                    = busy_r;
        assign o_expire[k]                  = expire_r;
        assign o_done[k]                    = done_r;
        assign o_count[k*CWIDTH +: CWIDTH]  = count_r;
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer with NCH=2, CWIDTH=4; prescaler test only when
// MULTI_TIMER_PRESCALE_EN is defined.
module tb_multi_timer;
    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int PW  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  start, stop, periodic;
    logic [NCH*CW-1:0] cycles;
    logic [PW-1:0]   prescale;
    logic [NCH-1:0]  busy, expire, done;
    logic [NCH*CW-1:0] count;

    int n_vec = 0;
    int n_err = 0;

    multi_timer #(.NCH(NCH), .CWIDTH(CW), .PWIDTH(PW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_stop     (stop),
        .i_periodic (periodic),
        .i_cycles   (cycles),
`ifdef MULTI_TIMER_PRESCALE_EN
        .i_prescale (prescale),
`endif
        .o_busy     (busy),
        .o_expire   (expire),
        .o_done     (done),
        .o_count    (count)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are sampled well after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = '0; stop = '0; periodic = '0; cycles = '0; prescale = '0;
        step(); step();
        rst = 1'b0;
        n_vec++;
        if ({busy, expire, done, count} !== '0) begin
            n_err++;
            $display("FAIL reset: got busy=%b exp=%b done=%b cnt=%h, want all 0", busy, expire, done, count);
        end
    endtask

    task automatic test_oneshot();
        cycles[3:0] = 4'd5; periodic[0] = 1'b0; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_vec++;
            if (expire[0] !== (i == 5) || count[3:0] !== 4'((i > 5) ? 5 : i)
                || busy[0] !== (i < 5) || done[0] !== (i >= 5)) begin
                n_err++;
                $display("FAIL oneshot edge %0d: exp=%b cnt=%0d busy=%b done=%b, want exp=%b cnt=%0d busy=%b done=%b",
                         i, expire[0], count[3:0], busy[0], done[0], (i == 5), (i > 5) ? 5 : i, (i < 5), (i >= 5));
            end
        end
    endtask

    task automatic test_periodic();
        cycles[7:4] = 4'd3; periodic[1] = 1'b1; start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_vec++;
            if (expire[1] !== (i % 3 == 0) || count[7:4] !== 4'(i % 3) || busy[1] !== 1'b1) begin
                n_err++;
                $display("FAIL periodic edge %0d: exp=%b cnt=%0d busy=%b, want exp=%b cnt=%0d busy=1",
                         i, expire[1], count[7:4], busy[1], (i % 3 == 0), i % 3);
            end
            n_vec++;
            if (expire[0] !== 1'b0 || count[3:0] !== 4'd5 || done[0] !== 1'b1 || busy[0] !== 1'b0) begin
                n_err++;
                $display("FAIL ch0_isolation edge %0d: exp=%b cnt=%0d done=%b busy=%b, want 0 5 1 0",
                         i, expire[0], count[3:0], done[0], busy[0]);
            end
        end
        stop[1] = 1'b1;
        step();
        stop[1] = 1'b0;
        n_vec++;
        if (busy[1] !== 1'b0 || expire[1] !== 1'b0 || count[7:4] !== 4'd1) begin
            n_err++;
            $display("FAIL periodic_stop: busy=%b exp=%b cnt=%0d, want 0 0 1", busy[1], expire[1], count[7:4]);
        end
    endtask

    task automatic test_stop();
        cycles[3:0] = 4'd8; periodic[0] = 1'b0; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        stop[0] = 1'b1;
        step();
        stop[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (busy[0] !== 1'b0 || expire[0] !== 1'b0 || count[3:0] !== 4'd4 || done[0] !== 1'b0) begin
                n_err++;
                $display("FAIL stop %0d: busy=%b exp=%b cnt=%0d done=%b, want 0 0 4 0",
                         i, busy[0], expire[0], count[3:0], done[0]);
            end
            step();
        end
        start[0] = 1'b1; stop[0] = 1'b1;
        step();
        start[0] = 1'b0; stop[0] = 1'b0;
        n_vec++;
        if (busy[0] !== 1'b0 || count[3:0] !== 4'd0) begin
            n_err++;
            $display("FAIL start_stop_armed: busy=%b cnt=%0d, want 0 0", busy[0], count[3:0]);
        end
        step();
        n_vec++;
        if (busy[0] !== 1'b1 || count[3:0] !== 4'd1) begin
            n_err++;
            $display("FAIL start_stop_run: busy=%b cnt=%0d, want 1 1", busy[0], count[3:0]);
        end
    endtask

    task automatic test_reset_mid_run();
        cycles = {4'd2, 4'd8}; periodic = 2'b10; start = 2'b11;
        step();
        start = 2'b00;
        for (int i = 0; i < 3; i++) step();
        n_vec++;
        if (count[3:0] !== 4'd3) begin
            n_err++;
            $display("FAIL pre_reset_count: cnt=%0d, want 3", count[3:0]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if ({busy, expire, done, count} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_run: busy=%b exp=%b done=%b cnt=%h, want all 0", busy, expire, done, count);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if ({busy, expire, done, count} !== '0) begin
                n_err++;
                $display("FAIL after_reset %0d: busy=%b exp=%b done=%b cnt=%h, want all 0", i, busy, expire, done, count);
            end
        end
    endtask

    task automatic test_boundaries();
        // N=0 behaves as N=1
        cycles[3:0] = 4'd0; periodic[0] = 1'b0; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        n_vec++;
        if (expire[0] !== 1'b1 || count[3:0] !== 4'd1 || busy[0] !== 1'b0 || done[0] !== 1'b1) begin
            n_err++;
            $display("FAIL n_zero: exp=%b cnt=%0d busy=%b done=%b, want 1 1 0 1", expire[0], count[3:0], busy[0], done[0]);
        end
        step();
        n_vec++;
        if (expire[0] !== 1'b0 || count[3:0] !== 4'd1) begin
            n_err++;
            $display("FAIL n_zero_after: exp=%b cnt=%0d, want 0 1", expire[0], count[3:0]);
        end
        // N=15 on both channels, ch0 one-shot, ch1 periodic
        cycles = {4'd15, 4'd15}; periodic = 2'b10; start = 2'b11;
        step();
        start = 2'b00;
        for (int i = 1; i <= 16; i++) begin
            step();
            n_vec++;
            if (expire !== ((i == 15) ? 2'b11 : 2'b00)
                || count[3:0] !== 4'((i >= 15) ? 15 : i)
                || count[7:4] !== 4'((i >= 15) ? i - 15 : i)) begin
                n_err++;
                $display("FAIL n_max edge %0d: exp=%b cnt0=%0d cnt1=%0d", i, expire, count[3:0], count[7:4]);
            end
        end
        n_vec++;
        if (busy !== 2'b10 || done !== 2'b11) begin
            n_err++;
            $display("FAIL n_max_state: busy=%b done=%b, want 10 11", busy, done);
        end
        stop[1] = 1'b1;
        step();
        stop[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        cycles[3:0] = 4'd5; periodic[0] = 1'b0; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        cycles[3:0] = 4'd2; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n_vec++;
        if (expire[0] !== 1'b0 || count[3:0] !== 4'd0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            n_err++;
            $display("FAIL restart: exp=%b cnt=%0d busy=%b done=%b, want 0 0 0 0", expire[0], count[3:0], busy[0], done[0]);
        end
        step();
        step();
        n_vec++;
        if (expire[0] !== 1'b1 || count[3:0] !== 4'd2) begin
            n_err++;
            $display("FAIL restart_expire: exp=%b cnt=%0d, want 1 2", expire[0], count[3:0]);
        end
    endtask

`ifdef MULTI_TIMER_PRESCALE_EN
    task automatic test_prescale();
        prescale = 8'd2; cycles[3:0] = 4'd4; periodic[0] = 1'b0; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            step();
            n_vec++;
            if (expire[0] !== (i == 12) || count[3:0] !== 4'((i >= 12) ? 4 : i / 3)) begin
                n_err++;
                $display("FAIL prescale edge %0d: exp=%b cnt=%0d, want exp=%b cnt=%0d",
                         i, expire[0], count[3:0], (i == 12), (i >= 12) ? 4 : i / 3);
            end
        end
        prescale = 8'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop();
        test_reset_mid_run();
        test_boundaries();
        test_back_to_back();
`ifdef MULTI_TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
